writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback mux for the pd3 RISC-V core.
- Captures memory-stage results, formats load data (byte/half extraction, sign/zero extension) and selects the writeback value.
- Drives rd/datawb/regwren directly into register_file.
- Also flags misaligned or illegal loads and keeps a retired-instruction counter.

Parameters:
DWIDTH, 32, data width of register file and datapath
AWIDTH, 32, PC/address width
CNTWIDTH, 64, width of retired-instruction counter

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-low
stall_i  input  1  hold WB register contents; suppress write and retire
flush_i  input  1  replace WB entry with bubble at next edge
valid_i  input  1  MEM stage holds a real instruction
pc_i  input  AWIDTH  instruction PC
rd_i  input  5  destination register
regwren_i  input  1  instruction writes rd
wbsel_i  input  2  writeback source select (wbsel_t)
alures_i  input  DWIDTH  ALU result; also load address
memdata_i  input  DWIDTH  raw aligned word from data memory
funct3_i  input  3  load type
rd_o  output  5  register_file rd_i
datawb_o  output  DWIDTH  register_file datawb_i
regwren_o  output  1  register_file regwren_i
retire_o  output  1  instruction retires this cycle
fault_o  output  1  misaligned/illegal load in WB this cycle
instret_o  output  CNTWIDTH  retired-instruction count

Behaviour:
- Reset (rst=0, async): valid_q=0; all captured fields 0; instret=0. Outputs: rd_o=0, datawb_o=0, regwren_o=0, retire_o=0, fault_o=0, instret_o=0.
- Capture, at posedge clk:
  - flush_i=1 → valid_q<=0 (flush beats stall).
  - else stall_i=1 → hold all fields.
  - else capture all inputs, valid_q<=valid_i.
- Latency: input sampled at edge N. datawb_o is valid combinationally after edge N. Register file writes at edge N+1.
- Load formatting (from captured alures[1:0], memdata, funct3):
  - LB (0): byte at addr[1:0], sign-extended.
  - LBU (4): byte at addr[1:0], zero-extended.
  - LH (1): half at addr[1], sign-extended.
  - LHU (5): half at addr[1], zero-extended.
  - LW (2): full word.
  - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Illegal: funct3 ∈ {3,6,7}.
  - Misaligned or illegal → load_fault=1, formatted data=0.
- Writeback mux:
  - WB_ALU → alures.
  - WB_MEM → formatted load.
  - WB_PC4 → pc+4, wrapping modulo 2^AWIDTH (0xFFFFFFFC → 0).
  - WB_NONE → 0.
- fault_o = valid_q & wbsel==WB_MEM & load_fault. Asserted regardless of stall.
- retire_o = valid_q & ~stall_i. Faulting instructions still retire.
- regwren_o = retire_o & regwren_q & (rd_q!=0) & ~fault_o.
- Stalled entries never write and are never counted twice.
- rd_o and datawb_o always reflect captured fields, even when regwren_o=0.
- instret: +1 on each posedge where retire_o=1. Wraps at 2^CNTWIDTH to 0.
- Stall with flush at the same edge: bubble inserted; the held entry is discarded without retiring.
- Reset mid-stall or mid-flush: async clear dominates immediately.

Decomposition:
- constants.svh package additions:
  - wbsel_t enum: WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_NONE=3.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- Sub-module load_formatter (combinational): inputs addr[1:0], memdata, funct3; outputs data and load_fault. Unit-testable alone.
- writeback_stage holds the pipeline register, mux, gating and counter.

Test Plan:
- Reset: rst=0 mid-cycle → all outputs 0 immediately. Release, one idle cycle → instret_o=0.
- ALU write: valid=1, rd=5, WB_ALU, alures=0x12345678 → after edge, regwren_o=1, rd_o=5, datawb_o=0x12345678, retire_o=1. instret_o=1 after next edge.
- Loads, memdata=0x8070F0FF:
  - LB, addr 0x..3 → 0xFFFFFF80.
  - LBU, addr 0x..2 → 0x00000070.
  - LH, addr 0x..0 → 0xFFFFF0FF.
  - LHU, addr 0x..2 → 0x00008070.
  - LW, addr 0x..0 → 0x8070F0FF.
- Faults and x0:
  - LW, addr 0x1002 → fault_o=1, regwren_o=0, retire_o=1.
  - funct3=3 → fault_o=1.
  - rd=0 write → regwren_o=0.
- PC+4: WB_PC4, pc=0xFFFFFFFC → datawb_o=0x00000000.
- Stall/flush:
  - Capture rd=7 (WB_ALU, 0xAAAA_AAAA), then stall 3 cycles → regwren_o=0, rd_o=7 held, instret unchanged; release → exactly one write and instret+1.
  - stall_i=1 and flush_i=1 together → no write, no retire.
- Integration: chain with register_file → after writing x9=0xCAFEBABE via WB, rs1_i=9 reads 0xCAFEBABE one edge later.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: writeback source select and load funct3 encodings
package writeback_stage_pkg;
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wbsel_t;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
endpackage

// File: rtl/writeback_stage_load_formatter.sv
// writeback_stage_load_formatter: byte/half extraction and extension of a loaded word, with fault detection
module writeback_stage_load_formatter
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [1:0]        addr,
  input  logic [DWIDTH-1:0] memdata,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] data,
  output logic              load_fault
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_mis;
  logic        w_ill;
  assign w_byte = memdata[{addr, 3'b000} +: 8];
  assign w_half = memdata[{addr[1], 4'b0000} +: 16];
  assign w_ill = funct3 == 3'd3 || funct3[2:1] == 2'b11;
  assign w_mis = ((funct3 == F3_LH || funct3 == F3_LHU) && addr[0]) ||
                 (funct3 == F3_LW && addr != 2'b00);
  assign load_fault = w_ill || w_mis;
  always_comb begin
    data = load_fault           ? '0 :
           funct3 == F3_LB      ? {{(DWIDTH-8){w_byte[7]}}, w_byte} :
           funct3 == F3_LBU     ? {{(DWIDTH-8){1'b0}}, w_byte} :
           funct3 == F3_LH      ? {{(DWIDTH-16){w_half[15]}}, w_half} :
           funct3 == F3_LHU     ? {{(DWIDTH-16){1'b0}}, w_half} :
                                  memdata;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, writeback mux, write/retire gating and instret counter
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int CNTWIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                valid_i,
  input  logic [AWIDTH-1:0]   pc_i,
  input  logic [4:0]          rd_i,
  input  logic                regwren_i,
  input  logic [1:0]          wbsel_i,
  input  logic [DWIDTH-1:0]   alures_i,
  input  logic [DWIDTH-1:0]   memdata_i,
  input  logic [2:0]          funct3_i,
  output logic [4:0]          rd_o,
  output logic [DWIDTH-1:0]   datawb_o,
  output logic                regwren_o,
  output logic                retire_o,
  output logic                fault_o,
  output logic [CNTWIDTH-1:0] instret_o
);
  logic                r_valid;
  logic [AWIDTH-1:0]   r_pc;
  logic [4:0]          r_rd;
  logic                r_regwren;
  wbsel_t              r_wbsel;
  logic [DWIDTH-1:0]   r_alures;
  logic [DWIDTH-1:0]   r_memdata;
  logic [2:0]          r_funct3;
  logic [CNTWIDTH-1:0] r_instret;
  logic [DWIDTH-1:0]   w_load;
  logic                w_load_fault;
  logic [AWIDTH-1:0]   w_pc4;
  writeback_stage_load_formatter #(.DWIDTH(DWIDTH)) u_fmt (
    .addr       (r_alures[1:0]),
    .memdata    (r_memdata),
    .funct3     (r_funct3),
    .data       (w_load),
    .load_fault (w_load_fault)
  );
  // flush beats stall; a stalled-and-flushed entry is dropped without retiring
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_regwren <= 1'b0;
      r_wbsel   <= WB_ALU;
      r_alures  <= '0;
      r_memdata <= '0;
      r_funct3  <= '0;
      r_instret <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (!stall_i) begin
        r_valid   <= valid_i;
        r_pc      <= pc_i;
        r_rd      <= rd_i;
        r_regwren <= regwren_i;
        r_wbsel   <= wbsel_t'(wbsel_i);
        r_alures  <= alures_i;
        r_memdata <= memdata_i;
        r_funct3  <= funct3_i;
      end
      if (retire_o) r_instret <= r_instret + CNTWIDTH'(1);
    end
  end
  assign w_pc4 = r_pc + AWIDTH'(4);
  always_comb begin
    datawb_o = r_wbsel == WB_ALU ? r_alures :
               r_wbsel == WB_MEM ? w_load :
               r_wbsel == WB_PC4 ? DWIDTH'(w_pc4) : '0;
  end
  assign rd_o      = r_rd;
  assign fault_o   = r_valid && r_wbsel == WB_MEM && w_load_fault;
  assign retire_o  = r_valid && !stall_i;
  assign regwren_o = retire_o && r_regwren && r_rd != 5'd0 && !fault_o;
  assign instret_o = r_instret;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench; the monitor checks each retiring entry against queued expectations
module tb_writeback_stage;
  import writeback_stage_pkg::*;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
    logic        w;
    logic        f;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [4:0]  rd_i = '0;
  logic        regwren_i = 1'b0;
  logic [1:0]  wbsel_i = '0;
  logic [31:0] alures_i = '0, memdata_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_o;
  logic [31:0] datawb_o;
  logic        regwren_o, retire_o, fault_o;
  logic [63:0] instret_o;
  int          n_cmp = 0, n_err = 0, n_ret = 0, n_w7 = 0;
  exp_t        q[$];
  logic [31:0] rf[32];
  writeback_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .rd_i(rd_i), .regwren_i(regwren_i), .wbsel_i(wbsel_i),
    .alures_i(alures_i), .memdata_i(memdata_i), .funct3_i(funct3_i),
    .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o), .retire_o(retire_o),
    .fault_o(fault_o), .instret_o(instret_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwren_o) begin
      rf[rd_o] <= datawb_o;
      if (rd_o == 5'd7) n_w7 <= n_w7 + 1;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && retire_o) begin
      if (q.size() == 0) begin
        chk("unexpected_retire", 64'(rd_o), 64'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_rd", 64'(rd_o), 64'(e.rd));
        chk("mon_data", 64'(datawb_o), 64'(e.d));
        chk("mon_wren", 64'(regwren_o), 64'(e.w));
        chk("mon_fault", 64'(fault_o), 64'(e.f));
      end
    end
  end
  task automatic issue(input logic push, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [2:0] f3, input logic [31:0] ed, input logic ew, input logic ef);
    valid_i = 1'b1; pc_i = pc; rd_i = rd; regwren_i = 1'b1; wbsel_i = sel;
    alures_i = alu; memdata_i = mem; funct3_i = f3;
    if (push) begin
      q.push_back('{rd: rd, d: ed, w: ew, f: ef});
      n_ret++;
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask
  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  localparam logic [31:0] MD = 32'h8070F0FF;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", 64'(rd_o), 64'd0);
    chk("reset_data", 64'(datawb_o), 64'd0);
    chk("reset_flags", {61'd0, regwren_o, retire_o, fault_o}, 64'd0);
    chk("reset_instret", instret_o, 64'd0);
    rst = 1'b1;
    issue(1'b0, 32'h0, 5'd3, WB_ALU, 32'hDEAD_BEEF, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_reset_rd", 64'(rd_o), 64'd0);
    chk("async_reset_data", 64'(datawb_o), 64'd0);
    chk("async_reset_flags", {61'd0, regwren_o, retire_o, fault_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    chk("instret_after_reset", instret_o, 64'd0);
    issue(1'b1, 32'h100, 5'd5, WB_ALU, 32'h12345678, 32'h0, 3'd0, 32'h12345678, 1'b1, 1'b0);
    chk("alu_wren_direct", 64'(regwren_o), 64'd1);
    chk("alu_retire_direct", 64'(retire_o), 64'd1);
    idle(1);
    chk("instret_one", instret_o, 64'd1);
    issue(1'b1, 32'h104, 5'd10, WB_MEM, 32'h2003, MD, F3_LB,  32'hFFFFFF80, 1'b1, 1'b0);
    issue(1'b1, 32'h108, 5'd11, WB_MEM, 32'h2002, MD, F3_LBU, 32'h00000070, 1'b1, 1'b0);
    issue(1'b1, 32'h10C, 5'd12, WB_MEM, 32'h2000, MD, F3_LH,  32'hFFFFF0FF, 1'b1, 1'b0);
    issue(1'b1, 32'h110, 5'd13, WB_MEM, 32'h2002, MD, F3_LHU, 32'h00008070, 1'b1, 1'b0);
    issue(1'b1, 32'h114, 5'd14, WB_MEM, 32'h2000, MD, F3_LW,  32'h8070F0FF, 1'b1, 1'b0);
    issue(1'b1, 32'h118, 5'd15, WB_MEM, 32'h1002, MD, F3_LW,  32'h00000000, 1'b0, 1'b1);
    issue(1'b1, 32'h11C, 5'd16, WB_MEM, 32'h2000, MD, 3'd3,   32'h00000000, 1'b0, 1'b1);
    issue(1'b1, 32'h120, 5'd17, WB_MEM, 32'h2001, MD, F3_LHU, 32'h00000000, 1'b0, 1'b1);
    issue(1'b1, 32'h124, 5'd18, WB_ALU, 32'h2001, MD, 3'd7,   32'h00002001, 1'b1, 1'b0);
    issue(1'b1, 32'h128, 5'd0,  WB_ALU, 32'h55,   MD, 3'd0,   32'h00000055, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFFFFFC, 5'd19, WB_PC4, 32'h1, MD, 3'd0, 32'h00000000, 1'b1, 1'b0);
    issue(1'b1, 32'h12C, 5'd20, WB_NONE, 32'h99, MD, 3'd0,    32'h00000000, 1'b1, 1'b0);
    idle(2);
    chk("instret_after_batch", instret_o, 64'(n_ret));
    issue(1'b1, 32'h130, 5'd7, WB_ALU, 32'hAAAA_AAAA, 32'h0, 3'd0, 32'hAAAA_AAAA, 1'b1, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wren", 64'(regwren_o), 64'd0);
      chk("stall_rd_held", 64'(rd_o), 64'd7);
      chk("stall_instret", instret_o, 64'(n_ret - 1));
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    idle(2);
    chk("stall_release_instret", instret_o, 64'(n_ret));
    chk("stall_single_write", 64'(n_w7), 64'd1);
    chk("stall_rf7", 64'(rf[7]), 64'hAAAA_AAAA);
    issue(1'b0, 32'h134, 5'd8, WB_ALU, 32'h1234, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0);
    stall_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("stflush_retire", 64'(retire_o), 64'd0);
    @(posedge clk); #1;
    stall_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("stflush_bubble", 64'({regwren_o, retire_o}), 64'd0);
    idle(1);
    chk("stflush_instret", instret_o, 64'(n_ret));
    chk("stflush_rf8", 64'(rf[8]), 64'd0);
    issue(1'b1, 32'h138, 5'd9, WB_ALU, 32'hCAFEBABE, 32'h0, 3'd0, 32'hCAFEBABE, 1'b1, 1'b0);
    idle(2);
    chk("rf_x9", 64'(rf[9]), 64'hCAFEBABE);
    chk("final_instret", instret_o, 64'(n_ret));
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
